// File: rtl/lane_serializer4.sv
// Serializes a 4-lane byte group from the recirculation demux onto one byte stream,
// lane 0 first, one lane per clock, with a ready handshake back upstream.
module lane_serializer4 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in0,
  input  logic [WIDTH-1:0] data_in1,
  input  logic [WIDTH-1:0] data_in2,
  input  logic [WIDTH-1:0] data_in3,
  input  logic             valid_in,
  output logic             ready_out,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  output logic [1:0]       lane_idx
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t           state_reg;
  logic [1:0]       cnt_reg;
  logic [WIDTH-1:0] hold_reg [4];
  logic [WIDTH-1:0] lane_in  [4];
  logic [4*WIDTH-1:0] lanes_flat;
  logic             accept;

  logic [WIDTH-1:0] data_out_reg;
  logic             valid_out_reg;
  logic [1:0]       lane_idx_reg;

  assign lanes_flat = {data_in3, data_in2, data_in1, data_in0};

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_in[gi] = lanes_flat[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Ready while idle, or on the last lane of a group so the next group follows with no bubble.
  assign ready_out = !reset && ((state_reg == IDLE) || ((state_reg == SEND) && (cnt_reg == 2'd3)));
  assign accept    = valid_in && ready_out;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= 2'd0;
      data_out_reg  <= '0;
      valid_out_reg <= 1'b0;
      lane_idx_reg  <= 2'd0;
      for (int i = 0; i < 4; i++) begin
        hold_reg[i] <= '0;
      end
    end else begin
      case (state_reg)
        IDLE: begin
          data_out_reg  <= '0;
          valid_out_reg <= 1'b0;
          lane_idx_reg  <= 2'd0;
          if (accept) begin
            for (int i = 0; i < 4; i++) begin
              hold_reg[i] <= lane_in[i];
            end
            cnt_reg   <= 2'd0;
            state_reg <= SEND;
          end
        end
        SEND: begin
          data_out_reg  <= hold_reg[cnt_reg];
          lane_idx_reg  <= cnt_reg;
          valid_out_reg <= 1'b1;
          if (cnt_reg != 2'd3) begin
            cnt_reg <= cnt_reg + 2'd1;
          end else begin
            cnt_reg <= 2'd0;
            // Reloading here is safe: lane 3 is read from the old hold value this same edge.
            if (accept) begin
              for (int i = 0; i < 4; i++) begin
                hold_reg[i] <= lane_in[i];
              end
            end else begin
              state_reg <= IDLE;
            end
          end
        end
        default: begin
          state_reg <= IDLE;
          cnt_reg   <= 2'd0;
        end
      endcase
    end
  end

  assign data_out  = data_out_reg;
  assign valid_out = valid_out_reg;
  assign lane_idx  = lane_idx_reg;

endmodule

// File: tb/tb_lane_serializer4.sv
// Self-checking bench for lane_serializer4: an edge-indexed schedule of expected bytes
// is built from each accepted group and compared against the serialized stream.
module tb_lane_serializer4;

  logic       clk;
  logic       reset;
  logic [7:0] data_in0, data_in1, data_in2, data_in3;
  logic       valid_in;
  logic       ready_out;
  logic [7:0] data_out;
  logic       valid_out;
  logic [1:0] lane_idx;

  int vecs = 0;
  int errs = 0;

  // Reference model: edge number -> expected output after that edge.
  int         edge_no  = 0;
  int         last_acc = -100;
  logic       in_reset = 1'b1;
  logic       sched_v [int];
  logic [7:0] sched_d [int];
  logic [1:0] sched_i [int];

  // Observed / expected values of the most recent cycle.
  logic       o_rdy, e_rdy, o_v, e_v, acc;
  logic [7:0] o_d, e_d;
  logic [1:0] o_i, e_i;

  lane_serializer4 #(.WIDTH(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .data_in0 (data_in0),
    .data_in1 (data_in1),
    .data_in2 (data_in2),
    .data_in3 (data_in3),
    .valid_in (valid_in),
    .ready_out(ready_out),
    .data_out (data_out),
    .valid_out(valid_out),
    .lane_idx (lane_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic model_ready();
    if (in_reset) return 1'b0;
    return (edge_no + 1) >= (last_acc + 4);
  endfunction

  // Drive one cycle (called #1 after a rising edge), advance the model, capture values.
  task automatic cycle(input logic v, input logic [31:0] g);
    valid_in = v;
    {data_in3, data_in2, data_in1, data_in0} = g;
    #1;
    o_rdy = ready_out;
    e_rdy = model_ready();
    acc   = v && e_rdy;
    if (acc) begin
      last_acc = edge_no + 1;
      for (int k = 0; k < 4; k++) begin
        sched_v[edge_no + 2 + k] = 1'b1;
        sched_d[edge_no + 2 + k] = g[8*k +: 8];
        sched_i[edge_no + 2 + k] = 2'(k);
      end
    end
    @(posedge clk);
    edge_no++;
    #1;
    o_v = valid_out;
    o_d = data_out;
    o_i = lane_idx;
    e_v = sched_v.exists(edge_no) ? sched_v[edge_no] : 1'b0;
    e_d = sched_d.exists(edge_no) ? sched_d[edge_no] : 8'h00;
    e_i = sched_i.exists(edge_no) ? sched_i[edge_no] : 2'd0;
  endtask

  task automatic test_reset();
    #1;
    vecs++; if (ready_out !== 1'b0) begin errs++; $display("FAIL reset_ready got=%0b exp=0", ready_out); end
    vecs++; if (valid_out !== 1'b0) begin errs++; $display("FAIL reset_valid got=%0b exp=0", valid_out); end
    vecs++; if (data_out !== 8'h00) begin errs++; $display("FAIL reset_data got=%02h exp=00", data_out); end
    vecs++; if (lane_idx !== 2'd0) begin errs++; $display("FAIL reset_idx got=%0d exp=0", lane_idx); end
    reset = 1'b0;
    in_reset = 1'b0;
    #1;
    vecs++; if (ready_out !== 1'b1) begin errs++; $display("FAIL release_ready got=%0b exp=1", ready_out); end
    vecs++; if (valid_out !== 1'b0) begin errs++; $display("FAIL release_valid got=%0b exp=0", valid_out); end
    @(posedge clk); edge_no++; #1;
    $display("reset: outputs zero during reset, ready after release");
  endtask

  task automatic test_single_group();
    logic [31:0] g;
    for (int c = 0; c < 8; c++) begin
      g = (c == 0) ? 32'h44332211 : 32'h00000000;
      cycle(c == 0, g);
      vecs++; if (o_rdy !== e_rdy) begin errs++; $display("FAIL single_ready c=%0d got=%0b exp=%0b", c, o_rdy, e_rdy); end
      vecs++; if (o_v !== e_v) begin errs++; $display("FAIL single_valid c=%0d got=%0b exp=%0b", c, o_v, e_v); end
      vecs++; if (o_d !== e_d) begin errs++; $display("FAIL single_data c=%0d got=%02h exp=%02h", c, o_d, e_d); end
      vecs++; if (o_i !== e_i) begin errs++; $display("FAIL single_idx c=%0d got=%0d exp=%0d", c, o_i, e_i); end
      $display("single c=%0d rdy=%0b v=%0b d=%02h lane=%0d", c, o_rdy, o_v, o_d, o_i);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] grp [2];
    int gsel = 0;
    int valid_run = 0;
    grp[0] = 32'hA3A2A1A0;
    grp[1] = 32'hB3B2B1B0;
    for (int c = 0; c < 14; c++) begin
      cycle(gsel < 2, (gsel < 2) ? grp[gsel] : 32'h0);
      if (acc) gsel++;
      if (o_v) valid_run++;
      vecs++; if (o_rdy !== e_rdy) begin errs++; $display("FAIL b2b_ready c=%0d got=%0b exp=%0b", c, o_rdy, e_rdy); end
      vecs++; if (o_v !== e_v) begin errs++; $display("FAIL b2b_valid c=%0d got=%0b exp=%0b", c, o_v, e_v); end
      vecs++; if (o_d !== e_d) begin errs++; $display("FAIL b2b_data c=%0d got=%02h exp=%02h", c, o_d, e_d); end
      vecs++; if (o_i !== e_i) begin errs++; $display("FAIL b2b_idx c=%0d got=%0d exp=%0d", c, o_i, e_i); end
      $display("b2b c=%0d rdy=%0b v=%0b d=%02h lane=%0d", c, o_rdy, o_v, o_d, o_i);
    end
    vecs++; if (valid_run !== 8) begin errs++; $display("FAIL b2b_count got=%0d exp=8", valid_run); end
  endtask

  task automatic test_stall();
    for (int c = 0; c < 8; c++) begin
      cycle(c < 3, (c == 0) ? 32'h0D0C0B0A : 32'hFFFFFFFF);
      vecs++; if (o_rdy !== e_rdy) begin errs++; $display("FAIL stall_ready c=%0d got=%0b exp=%0b", c, o_rdy, e_rdy); end
      vecs++; if (o_v !== e_v) begin errs++; $display("FAIL stall_valid c=%0d got=%0b exp=%0b", c, o_v, e_v); end
      vecs++; if (o_d !== e_d) begin errs++; $display("FAIL stall_data c=%0d got=%02h exp=%02h", c, o_d, e_d); end
      vecs++; if (o_i !== e_i) begin errs++; $display("FAIL stall_idx c=%0d got=%0d exp=%0d", c, o_i, e_i); end
      $display("stall c=%0d rdy=%0b v=%0b d=%02h lane=%0d", c, o_rdy, o_v, o_d, o_i);
    end
  endtask

  task automatic test_zero_data();
    for (int c = 0; c < 16; c++) begin
      cycle(c == 10, 32'h00000000);
      vecs++; if (o_rdy !== e_rdy) begin errs++; $display("FAIL zero_ready c=%0d got=%0b exp=%0b", c, o_rdy, e_rdy); end
      vecs++; if (o_v !== e_v) begin errs++; $display("FAIL zero_valid c=%0d got=%0b exp=%0b", c, o_v, e_v); end
      vecs++; if (o_d !== e_d) begin errs++; $display("FAIL zero_data c=%0d got=%02h exp=%02h", c, o_d, e_d); end
      vecs++; if (o_i !== e_i) begin errs++; $display("FAIL zero_idx c=%0d got=%0d exp=%0d", c, o_i, e_i); end
      $display("zero c=%0d rdy=%0b v=%0b d=%02h lane=%0d", c, o_rdy, o_v, o_d, o_i);
    end
  endtask

  task automatic test_reset_during_send();
    for (int c = 0; c < 3; c++) cycle(c == 0, 32'h44434241);
    // Lane 1 has just been emitted; reset lands mid-cycle.
    reset = 1'b1;
    in_reset = 1'b1;
    sched_v.delete(); sched_d.delete(); sched_i.delete();
    last_acc = -100;
    #1;
    vecs++; if (valid_out !== 1'b0) begin errs++; $display("FAIL rst_send_valid got=%0b exp=0", valid_out); end
    vecs++; if (data_out !== 8'h00) begin errs++; $display("FAIL rst_send_data got=%02h exp=00", data_out); end
    vecs++; if (ready_out !== 1'b0) begin errs++; $display("FAIL rst_send_ready got=%0b exp=0", ready_out); end
    @(posedge clk); edge_no++; #1;
    reset = 1'b0;
    in_reset = 1'b0;
    $display("reset during send applied");
    for (int c = 0; c < 7; c++) begin
      cycle(c == 0, 32'h5D5C5B5A);
      vecs++; if (o_rdy !== e_rdy) begin errs++; $display("FAIL rst_new_ready c=%0d got=%0b exp=%0b", c, o_rdy, e_rdy); end
      vecs++; if (o_v !== e_v) begin errs++; $display("FAIL rst_new_valid c=%0d got=%0b exp=%0b", c, o_v, e_v); end
      vecs++; if (o_d !== e_d) begin errs++; $display("FAIL rst_new_data c=%0d got=%02h exp=%02h", c, o_d, e_d); end
      vecs++; if (o_i !== e_i) begin errs++; $display("FAIL rst_new_idx c=%0d got=%0d exp=%0d", c, o_i, e_i); end
      $display("after_rst c=%0d rdy=%0b v=%0b d=%02h lane=%0d", c, o_rdy, o_v, o_d, o_i);
    end
  endtask

  task automatic test_random();
    logic        v;
    logic [31:0] g;
    for (int c = 0; c < 300; c++) begin
      v = ($urandom_range(0, 3) != 0);
      g = $urandom;
      cycle(v, g);
      vecs++; if (o_rdy !== e_rdy) begin errs++; $display("FAIL rand_ready c=%0d got=%0b exp=%0b", c, o_rdy, e_rdy); end
      vecs++; if (o_v !== e_v) begin errs++; $display("FAIL rand_valid c=%0d got=%0b exp=%0b", c, o_v, e_v); end
      vecs++; if (o_d !== e_d) begin errs++; $display("FAIL rand_data c=%0d got=%02h exp=%02h", c, o_d, e_d); end
      vecs++; if (o_i !== e_i) begin errs++; $display("FAIL rand_idx c=%0d got=%0d exp=%0d", c, o_i, e_i); end
      $display("rand c=%0d vin=%0b acc=%0b v=%0b d=%02h lane=%0d", c, v, acc, o_v, o_d, o_i);
    end
  endtask

  initial begin
    reset    = 1'b1;
    valid_in = 1'b0;
    data_in0 = 8'h00;
    data_in1 = 8'h00;
    data_in2 = 8'h00;
    data_in3 = 8'h00;
    @(posedge clk); edge_no++;
    test_reset();
    test_single_group();
    test_back_to_back();
    test_stall();
    test_zero_data();
    test_reset_during_send();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
